// File: rtl/fu_pkg.sv
// Shared definitions for the 8-bit function unit, its decode, the control
// path and the command sequencer.
package fu_pkg;

    // FunSel codes understood by the function unit.
    localparam logic [3:0] FS_NOP  = 4'h0; // transfer A
    localparam logic [3:0] FS_NOTA = 4'h1;
    localparam logic [3:0] FS_B    = 4'h2;
    localparam logic [3:0] FS_NOTB = 4'h3;
    localparam logic [3:0] FS_ADD  = 4'h4; // C = unsigned carry-out
    localparam logic [3:0] FS_SUB  = 4'h5;
    localparam logic [3:0] FS_AND  = 4'h6;
    localparam logic [3:0] FS_OR   = 4'h7;
    localparam logic [3:0] FS_XOR  = 4'h8;
    localparam logic [3:0] FS_SHL  = 4'h9;
    localparam logic [3:0] FS_SHR  = 4'hA;

    // Request op codes; 2'b10 and 2'b11 are reserved.
    localparam logic [1:0] OP_SINGLE = 2'b00;
    localparam logic [1:0] OP_MUL    = 2'b01;

    // Bit positions inside the packed {V,C,N,Z} flag nibble.
    localparam int FLAG_V = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MUL_ADD,
        ST_MUL_SHIFT,
        ST_DONE
    } seq_state_e;

    // Pack individual flags into the response nibble.
    function automatic logic [3:0] pack_flags(input logic v, input logic c,
                                              input logic n, input logic z);
        logic [3:0] f;
        f         = '0;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/fu_sequencer_if.sv
// Request, response and function-unit bus of the sequencer. The slave
// modport is the sequencer's view; master is the control path / responder.
interface fu_sequencer_if #(
    parameter int size = 8
);
    // request handshake
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [3:0]      req_fsel;
    logic [size-1:0] req_a;
    logic [size-1:0] req_b;
    // function unit bus
    logic [3:0]      fu_sel;
    logic [size-1:0] fu_a;
    logic [size-1:0] fu_b;
    logic [size-1:0] fu_out;
    logic            fu_v;
    logic            fu_c;
    logic            fu_n;
    logic            fu_z;
    // response handshake
    logic            rsp_valid;
    logic            rsp_ready;
    logic [size-1:0] rsp_lo;
    logic [size-1:0] rsp_hi;
    logic [3:0]      rsp_flags;
    logic            rsp_err;

    modport slave (
        input  req_valid, req_op, req_fsel, req_a, req_b,
        output req_ready,
        output fu_sel, fu_a, fu_b,
        input  fu_out, fu_v, fu_c, fu_n, fu_z,
        output rsp_valid, rsp_lo, rsp_hi, rsp_flags, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_op, req_fsel, req_a, req_b,
        input  req_ready,
        input  fu_sel, fu_a, fu_b,
        output fu_out, fu_v, fu_c, fu_n, fu_z,
        input  rsp_valid, rsp_lo, rsp_hi, rsp_flags, rsp_err,
        output rsp_ready
    );

endinterface

// File: rtl/fu_sequencer.sv
// Command sequencer for the function unit: single ops take one execute
// cycle; unsigned multiply runs 8 add/shift iterations through the adder.
module fu_sequencer
    import fu_pkg::*;
#(
    parameter int size = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    fu_sequencer_if.slave  bus,
    output logic           busy
);

    seq_state_e      state_q, state_d;
    logic [3:0]      fsel_q, fsel_d;
    logic [size-1:0] a_q, a_d;      // operand A / multiplicand
    logic [size-1:0] b_q, b_d;      // operand B
    logic [size-1:0] hi_q, hi_d;    // partial product high half
    logic [size-1:0] lo_q, lo_d;    // multiplier, shifted out as product low half
    logic            c_q, c_d;      // adder carry held for the shift
    logic [2:0]      iter_q, iter_d;
    logic [size-1:0] rsp_lo_q, rsp_lo_d;
    logic [size-1:0] rsp_hi_q, rsp_hi_d;
    logic [3:0]      rsp_flags_q, rsp_flags_d;
    logic            rsp_err_q, rsp_err_d;

    // {c,hi,lo} shifted right by one: the value after the current shift step.
    logic [size-1:0] sh_hi, sh_lo;
    assign sh_hi = {c_q, hi_q[size-1:1]};
    assign sh_lo = {hi_q[0], lo_q[size-1:1]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Datapath and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsel_q      <= FS_NOP;
            a_q         <= '0;
            b_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            c_q         <= 1'b0;
            iter_q      <= '0;
            rsp_lo_q    <= '0;
            rsp_hi_q    <= '0;
            rsp_flags_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            fsel_q      <= fsel_d;
            a_q         <= a_d;
            b_q         <= b_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            c_q         <= c_d;
            iter_q      <= iter_d;
            rsp_lo_q    <= rsp_lo_d;
            rsp_hi_q    <= rsp_hi_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        fsel_d      = fsel_q;
        a_d         = a_q;
        b_d         = b_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        c_d         = c_q;
        iter_d      = iter_q;
        rsp_lo_d    = rsp_lo_q;
        rsp_hi_d    = rsp_hi_q;
        rsp_flags_d = rsp_flags_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    rsp_err_d = 1'b0;
                    case (bus.req_op)
                        OP_SINGLE: begin
                            fsel_d  = bus.req_fsel;
                            a_d     = bus.req_a;
                            b_d     = bus.req_b;
                            state_d = ST_EXEC;
                        end
                        OP_MUL: begin
                            a_d     = bus.req_a;
                            hi_d    = '0;
                            lo_d    = bus.req_b;
                            c_d     = 1'b0;
                            iter_d  = '0;
                            state_d = ST_MUL_ADD;
                        end
                        default: begin
                            rsp_err_d   = 1'b1;
                            rsp_lo_d    = '0;
                            rsp_hi_d    = '0;
                            rsp_flags_d = '0;
                            state_d     = ST_DONE;
                        end
                    endcase
                end
            end
            ST_EXEC: begin
                rsp_lo_d    = bus.fu_out;
                rsp_hi_d    = '0;
                rsp_flags_d = pack_flags(bus.fu_v, bus.fu_c, bus.fu_n, bus.fu_z);
                state_d     = ST_DONE;
            end
            ST_MUL_ADD: begin
                hi_d    = bus.fu_out;
                c_d     = bus.fu_c;
                state_d = ST_MUL_SHIFT;
            end
            ST_MUL_SHIFT: begin
                hi_d   = sh_hi;
                lo_d   = sh_lo;
                c_d    = 1'b0;
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    // V flags a product that does not fit in size bits.
                    rsp_lo_d    = sh_lo;
                    rsp_hi_d    = sh_hi;
                    rsp_flags_d = pack_flags(sh_hi != '0, 1'b0, sh_hi[size-1],
                                             {sh_hi, sh_lo} == '0);
                    state_d     = ST_DONE;
                end else begin
                    state_d = ST_MUL_ADD;
                end
            end
            ST_DONE: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Function-unit drive and handshake outputs, decoded from state.
    always_comb begin
        bus.fu_sel = FS_NOP;
        bus.fu_a   = '0;
        bus.fu_b   = '0;
        case (state_q)
            ST_EXEC: begin
                bus.fu_sel = fsel_q;
                bus.fu_a   = a_q;
                bus.fu_b   = b_q;
            end
            ST_MUL_ADD: begin
                bus.fu_sel = FS_ADD;
                bus.fu_a   = hi_q;
                bus.fu_b   = lo_q[0] ? a_q : '0;
            end
            default: ;
        endcase
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_DONE);
    assign bus.rsp_lo    = rsp_lo_q;
    assign bus.rsp_hi    = rsp_hi_q;
    assign bus.rsp_flags = rsp_flags_q;
    assign bus.rsp_err   = rsp_err_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: doc/fu_sequencer.md
Name: fu_sequencer

Overview:
- Command-side initiator for the 8-bit function unit: accepts operation requests over a valid/ready handshake and drives FunSel, dataA and dataB.
- Captures the function-unit result and flags, and returns a response over a second valid/ready handshake.
- Single function-unit operations complete in one execute cycle. Unsigned multiply is sequenced as 8 add/shift iterations through the unit's adder.
- Sits between the control path and the function unit.

Parameters:
- size, 8, operand/result width; must match the function unit width.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  sequencer can accept a request (high only in IDLE)
- req_op  input  2  00 SINGLE, 01 MUL, 10/11 reserved
- req_fsel  input  4  FunSel for SINGLE; ignored otherwise
- req_a  input  size  operand A (MUL: multiplicand)
- req_b  input  size  operand B (MUL: multiplier)
- fu_sel  output  4  FunSel to function unit
- fu_a  output  size  dataA to function unit
- fu_b  output  size  dataB to function unit
- fu_out  input  size  FuntionOut from function unit
- fu_v, fu_c, fu_n, fu_z  input  1 each  function unit flags
- rsp_valid  output  1  response held until accepted
- rsp_ready  input  1  consumer accepts response
- rsp_lo  output  size  result (MUL: product low byte)
- rsp_hi  output  size  MUL: product high byte; SINGLE: 0
- rsp_flags  output  4  {V,C,N,Z}
- rsp_err  output  1  reserved op requested
- busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE
  - req_ready=1, rsp_valid=0, rsp_lo/hi=0, rsp_flags=0, rsp_err=0, busy=0
  - fu_sel=FS_NOP, fu_a=0, fu_b=0
- Reset mid-operation discards the in-flight request and any pending response. No response is produced for it.
- States: IDLE, EXEC, MUL_ADD, MUL_SHIFT, DONE.
- IDLE:
  - req_valid & req_ready at edge E0 latches op, fsel, a, b.
  - Next state: SINGLE->EXEC; MUL->MUL_ADD with hi=0, lo=req_b, mcand=req_a, iter=0, c=0; reserved->DONE with rsp_err=1, rsp_lo/hi/flags=0.
- EXEC (one cycle):
  - fu_sel=fsel, fu_a=a, fu_b=b.
  - At the edge: rsp_lo=fu_out, rsp_hi=0, rsp_flags={fu_v,fu_c,fu_n,fu_z}; go to DONE.
  - rsp_valid is visible in the cycle after EXEC: 2 cycles after E0.
- MUL_ADD:
  - fu_sel=FS_ADD, fu_a=hi, fu_b = lo[0] ? mcand : 0.
  - At the edge: hi=fu_out, c=fu_c (FS_ADD's C is the unsigned carry-out); go to MUL_SHIFT.
- MUL_SHIFT:
  - fu_sel=FS_NOP, fu_a=fu_b=0.
  - Local shift: {c,hi,lo} >>= 1, i.e. hi={c,hi[7:1]}, lo={hi[0],lo[7:1]}; c=0; iter++.
  - iter==7 at the edge -> DONE, else MUL_ADD.
  - Exactly 16 cycles MUL_ADD/MUL_SHIFT; rsp_valid visible 17 cycles after E0.
- MUL response flags:
  - Z = ({hi,lo}==0), N = hi[7], C=0, V = (hi!=0), i.e. product does not fit size bits.
- DONE:
  - rsp_* stable while rsp_valid=1 and rsp_ready=0.
  - rsp_valid & rsp_ready at an edge -> IDLE, rsp_valid=0. req_ready returns high the following cycle; no same-cycle turnaround.
- req_ready=0 in all non-IDLE states; req_valid is ignored there.
- fu_* outputs are FS_NOP/0 whenever not in EXEC or MUL_ADD.
- rsp_err is cleared on acceptance of the next request.

Decomposition:
- Shared package fu_pkg holds:
  - FunSel constants: FS_NOP (transfer A), FS_ADD, plus the logic/shift codes.
  - Op codes OP_SINGLE, OP_MUL.
  - State enum.
  - Flag bit positions V=3, C=2, N=1, Z=0.
- fu_pkg is also used by the function unit decode and the control path.
- No sub-module: one FSM plus datapath registers. The bench instantiates the real function unit as the responder.

Test Plan:
- SINGLE, fsel=FS_ADD, a=8'h0F, b=8'h01, rsp_ready=1 -> rsp_valid 2 cycles after E0, rsp_lo=8'h10, rsp_hi=0, flags Z=0, N=0, C=0.
- MUL, a=8'hFF, b=8'hFF -> rsp_valid 17 cycles after E0, {rsp_hi,rsp_lo}=16'hFE01, V=1, N=1, Z=0. fu_sel observed FS_ADD on exactly 8 cycles.
- MUL, a=8'h00, b=8'h55 -> product 0, Z=1, V=0. MUL a=8'h0C, b=8'h0A -> 16'h0078, V=0.
- Backpressure: SINGLE completes with rsp_ready=0 for 5 cycles -> rsp_valid, rsp_lo and flags constant; req_ready=0 and a second req_valid is not accepted. After rsp_ready pulse -> IDLE, second request accepted.
- Reset: rst_n low for 1 cycle during MUL iter 3 -> all outputs at reset values immediately (asynchronous), no response emitted. A following MUL 8'h03*8'h05 returns 16'h000F.
- Reserved op 2'b10 -> rsp_valid 1 cycle after E0, rsp_err=1, rsp_lo=rsp_hi=0. Next valid SINGLE returns rsp_err=0.
